mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multi-cycle multiply/divide sequencer for RV32M MUL/DIV/DIVU/REM/REMU. It time-shares the core's single combinational ALU: each cycle it drives the ALU opcode and operands and registers the ALU result. It sits beside the execute stage, which uses a valid/ready handshake on both the request and the response side.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU opcode width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_funct3  in  3  000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes act as MUL
- req_a, req_b  in  DATA_WIDTH  dividend/multiplicand, divisor/multiplier
- kill  in  1  synchronous abort; return to IDLE, no response
- resp_valid  out  1  result held valid in DONE
- resp_ready  in  1  consumer accepts
- resp_data  out  DATA_WIDTH  result
- busy  out  1  state != IDLE
- alu_op  out  OPCODE_LENGTH  to ALU Operation
- alu_src_a, alu_src_b  out  DATA_WIDTH  to ALU SrcA/SrcB
- alu_result  in  DATA_WIDTH  from ALU ALUResult (combinational, same cycle)

## Operation
- States: IDLE, NEG_A, NEG_B, ITER, NEG_R, DONE.
- IDLE: on req_valid&&req_ready latch operands, funct3, sign flags (signed ops only), and div_by_zero = (req_b==0). MUL goes to ITER; div ops go to NEG_A. Iteration counter resets to 0.
- NEG_A / NEG_B:
  - ALU SUB with SrcA=0, SrcB=a (or b).
  - The operand register takes alu_result only when the op is signed and that operand is negative.
  - These states are always traversed for div ops, giving fixed latency.
- ITER, MUL (shift-add):
  - ALU ADD, SrcA=acc, SrcB=mcand.
  - acc <= mplier[0] ? alu_result : acc.
  - mcand <<= 1, mplier >>= 1 (internal shifts).
  - Runs DATA_WIDTH cycles, then DONE.
- ITER, div (restoring):
  - rs = {rem[W-2:0], dvd[W-1]}.
  - ALU SUB with SrcA=rs, SrcB=divisor.
  - If rs >= divisor (internal unsigned compare): rem <= alu_result, quotient bit 1.
  - Else: rem <= rs, quotient bit 0.
  - dvd shifts left, quotient bits shift in at LSB.
  - Runs DATA_WIDTH cycles, then NEG_R.
- NEG_R:
  - ALU SUB 0 - selected result (quotient for DIV/DIVU, remainder for REM/REMU).
  - Negate the quotient iff signed, signs differ, and !div_by_zero.
  - Negate the remainder iff signed and dividend negative.
- Edge cases: divide-by-zero gives quotient all-ones and remainder = dividend. Overflow (MIN / -1) gives MIN and remainder 0. Both fall out of the algorithm plus the rules above.
- DONE: resp_valid=1, resp_data stable. On resp_ready go to IDLE.
- kill in any non-IDLE state forces IDLE next cycle and suppresses the response. kill in IDLE has no effect. kill has priority over request acceptance and resp_ready.
- When not used, ALU drive is alu_op=ADD (4'b0010), both sources 0.

## Timing
- Reset values:
  - state IDLE.
  - req_ready=1, resp_valid=0, busy=0, resp_data=0.
  - alu_op=4'b0010, alu_src_a=alu_src_b=0.
  - All internal registers 0.
- Reset mid-operation drops the operation immediately; no response is produced.
- Accept cycle = cycle 0. resp_valid rises:
  - MUL: cycle DATA_WIDTH+1 (33).
  - Div ops: cycle DATA_WIDTH+4 (36).
- Back-to-back operation: the earliest next accept is the cycle after a DONE handshake (one IDLE cycle minimum).
- resp_valid never drops without resp_ready or kill.
- alu_* outputs are registered-state driven only: they are a combinational function of state and registers, never of req_* inputs.

## Configuration
- MDU_DIV_EN defined: full behaviour as above.
- MDU_DIV_EN undefined:
  - Divider datapath, NEG_A, NEG_B and NEG_R are removed.
  - Div funct3 requests go IDLE -> DONE with resp_data=0 (resp_valid at cycle 1).
  - MUL is unchanged.

## Structure
- Package alu_pkg holds:
  - ALU opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_XOR=4'b0011, ALU_SUB=4'b0100, ALU_SLT=4'b0101, ALU_SLL=4'b0110, ALU_SRL=4'b0111, ALU_EQ=4'b1000, ALU_SRA=4'b1001.
  - The mdu_state_t enum.
  - The funct3 constants.
- No sub-module: the FSM and datapath registers live in mdu_sequencer. The ALU instance belongs to the parent and is shared through a mux there.

## Test plan
- MUL 7×6 -> resp_data 42, resp_valid at cycle 33.
- MUL 0xFFFFFFFF×2 -> 0xFFFFFFFE.
- DIV -7/2:
  - DIV -> 0xFFFFFFFD at cycle 36.
  - REM same operands -> 0xFFFFFFFF.
- Edge divides:
  - DIVU 10/0 -> 0xFFFFFFFF.
  - REMU 10/0 -> 10.
  - DIV -5/0 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Backpressure: resp_ready low for 5 cycles in DONE.
  - resp_valid and resp_data stay stable.
  - req_ready stays 0; a new request is not accepted until after the handshake.
- kill at ITER cycle 10 -> IDLE next cycle, no resp_valid, new request accepted normally. rst_n asserted mid-ITER -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, RV32M funct3 codes and the MDU sequencer state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_SRA = 4'b1001;

    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        ITER,
        NEG_R,
        DONE
    } mdu_state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_sdiv(input logic [2:0] f3);
        return f3[2] & ~f3[0];
    endfunction

endpackage

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer driving the core's shared ALU one step per cycle.
// Define MDU_DIV_EN to include the divider; otherwise div requests answer 0.
module mdu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_funct3,
    input  logic [DATA_WIDTH-1:0]    req_a,
    input  logic [DATA_WIDTH-1:0]    req_b,
    input  logic                     kill,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     busy,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int CW = $clog2(DATA_WIDTH);

    mdu_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_resp;
    logic [CW-1:0]         r_cnt;

    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_acc_nxt;
    logic [3:0]            w_op;
    logic [DATA_WIDTH-1:0] w_sa;
    logic [DATA_WIDTH-1:0] w_sb;

    assign w_last    = (r_cnt == CW'(DATA_WIDTH - 1));
    assign w_acc_nxt = r_b[0] ? alu_result : r_acc;

`ifdef MDU_DIV_EN
    // r_a doubles as dividend and quotient: quotient bits enter at the LSB.
    logic [2:0]            r_f3;
    logic                  r_sa;
    logic                  r_sb;
    logic                  r_dz;
    logic [DATA_WIDTH-1:0] w_rs;
    logic [DATA_WIDTH-1:0] w_sel;
    logic                  w_ge;
    logic                  w_neg;

    assign w_rs  = {r_acc[DATA_WIDTH-2:0], r_a[DATA_WIDTH-1]};
    assign w_ge  = (w_rs >= r_b);
    assign w_sel = r_f3[1] ? r_acc : r_a;
    assign w_neg = r_f3[1] ? r_sa : ((r_sa ^ r_sb) && !r_dz);
`endif

    always_comb begin
        w_op = ALU_ADD;
        w_sa = '0;
        w_sb = '0;
        unique case (r_state)
            ITER: begin
`ifdef MDU_DIV_EN
                if (r_f3[2]) begin
                    w_op = ALU_SUB;
                    w_sa = w_rs;
                    w_sb = r_b;
                end else
`endif
                begin
                    w_sa = r_acc;
                    w_sb = r_a;
                end
            end
`ifdef MDU_DIV_EN
            NEG_A: begin
                w_op = ALU_SUB;
                w_sb = r_a;
            end
            NEG_B: begin
                w_op = ALU_SUB;
                w_sb = r_b;
            end
            NEG_R: begin
                w_op = ALU_SUB;
                w_sb = w_sel;
            end
`endif
            default: ;
        endcase
    end

    assign alu_op     = OPCODE_LENGTH'(w_op);
    assign alu_src_a  = w_sa;
    assign alu_src_b  = w_sb;
    assign req_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign resp_valid = (r_state == DONE);
    assign resp_data  = r_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_resp  <= '0;
            r_cnt   <= '0;
`ifdef MDU_DIV_EN
            r_f3    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
`endif
        end else if (kill && r_state != IDLE) begin
            r_state <= IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a   <= req_a;
                        r_b   <= req_b;
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef MDU_DIV_EN
                        r_f3  <= req_funct3;
                        r_sa  <= is_sdiv(req_funct3)
                                 && req_a[DATA_WIDTH-1];
                        r_sb  <= is_sdiv(req_funct3)
                                 && req_b[DATA_WIDTH-1];
                        r_dz  <= (req_b == '0);
                        r_state <= is_div(req_funct3) ? NEG_A : ITER;
`else
                        if (is_div(req_funct3)) begin
                            r_resp  <= '0;
                            r_state <= DONE;
                        end else begin
                            r_state <= ITER;
                        end
`endif
                    end
                end
                ITER: begin
                    r_cnt <= r_cnt + 1'b1;
`ifdef MDU_DIV_EN
                    if (r_f3[2]) begin
                        r_acc <= w_ge ? alu_result : w_rs;
                        r_a   <= {r_a[DATA_WIDTH-2:0], w_ge};
                        if (w_last) r_state <= NEG_R;
                    end else
`endif
                    begin
                        r_acc <= w_acc_nxt;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                        if (w_last) begin
                            r_resp  <= w_acc_nxt;
                            r_state <= DONE;
                        end
                    end
                end
`ifdef MDU_DIV_EN
                NEG_A: begin
                    if (r_sa) r_a <= alu_result;
                    r_state <= NEG_B;
                end
                NEG_B: begin
                    if (r_sb) r_b <= alu_result;
                    r_state <= ITER;
                end
                NEG_R: begin
                    r_resp  <= w_neg ? alu_result : w_sel;
                    r_state <= DONE;
                end
`endif
                DONE: begin
                    if (resp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a behavioural ALU beside it.
// Div expectations follow whether MDU_DIV_EN is defined.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        kill = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        busy;
    logic [3:0]  alu_op;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [31:0] alu_result;

    int vectors = 0;
    int errors  = 0;

`ifdef MDU_DIV_EN
    localparam int DIV_LAT = 36;
`else
    localparam int DIV_LAT = 1;
`endif

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            4'b0000: alu_result = alu_src_a & alu_src_b;
            4'b0001: alu_result = alu_src_a | alu_src_b;
            4'b0010: alu_result = alu_src_a + alu_src_b;
            4'b0011: alu_result = alu_src_a ^ alu_src_b;
            4'b0100: alu_result = alu_src_a - alu_src_b;
            default: alu_result = '0;
        endcase
    end

    mdu_sequencer #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_result (alu_result)
    );

    function automatic logic [31:0] dx(input logic [31:0] v);
`ifdef MDU_DIV_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input int exp_lat);
        int n;
        req_funct3 = f3;
        req_a      = a;
        req_b      = b;
        req_valid  = 1'b1;
        chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_data"}, resp_data, exp_d);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_drop"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        tick();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_aluop", {28'b0, alu_op}, 32'd2);
        chk("rst_srca", alu_src_a, 32'd0);
        chk("rst_srcb", alu_src_b, 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, 33);
        do_op("mul_neg1x2", 3'b000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
        do_op("mul_f3_001", 3'b001, 32'd3, 32'd5, 32'd15, 33);
        do_op("mul_big", 3'b000, 32'h00012345, 32'h00010000,
              32'h23450000, 33);
        do_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2,
              dx(32'hFFFFFFFD), DIV_LAT);
        do_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2,
              dx(32'hFFFFFFFF), DIV_LAT);
        do_op("div_7_m2", 3'b100, 32'd7, 32'hFFFFFFFE,
              dx(32'hFFFFFFFD), DIV_LAT);
        do_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFFFFFE, dx(32'd1), DIV_LAT);
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7, dx(32'd14), DIV_LAT);
        do_op("remu_100_7", 3'b111, 32'd100, 32'd7, dx(32'd2), DIV_LAT);
        do_op("divu_by0", 3'b101, 32'd10, 32'd0, dx(32'hFFFFFFFF), DIV_LAT);
        do_op("remu_by0", 3'b111, 32'd10, 32'd0, dx(32'd10), DIV_LAT);
        do_op("div_m5_by0", 3'b100, 32'hFFFFFFFB, 32'd0,
              dx(32'hFFFFFFFF), DIV_LAT);
        do_op("rem_m5_by0", 3'b110, 32'hFFFFFFFB, 32'd0,
              dx(32'hFFFFFFFB), DIV_LAT);
        do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF,
              dx(32'h80000000), DIV_LAT);
        do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF,
              dx(32'd0), DIV_LAT);
        chk("idle_aluop", {28'b0, alu_op}, 32'd2);

        // Backpressure: hold resp_ready low while a new request waits.
        req_funct3 = 3'b000;
        req_a = 32'd7;
        req_b = 32'd6;
        req_valid = 1'b1;
        tick();
        req_a = 32'd2;
        req_b = 32'd3;
        for (int i = 0; i < 40 && !resp_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_data", resp_data, 32'd42);
            chk("bp_ready", {31'b0, req_ready}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("bp_idle", {31'b0, busy}, 32'd0);
        chk("bp_rdy", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        tick();

        // Abort during iteration cycle 10.
        req_funct3 = 3'b000;
        req_a = 32'd11;
        req_b = 32'd11;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        chk("kill_busy_pre", {31'b0, busy}, 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk("kill_busy", {31'b0, busy}, 32'd0);
        chk("kill_rdy", {31'b0, req_ready}, 32'd1);
        chk("kill_aluop", {28'b0, alu_op}, 32'd2);
        for (int i = 0; i < 30; i++) begin
            if (resp_valid) chk("kill_noresp", 32'd1, 32'd0);
            tick();
        end
        chk("kill_valid", {31'b0, resp_valid}, 32'd0);
        do_op("mul_after_kill", 3'b000, 32'd9, 32'd9, 32'd81, 33);

        // Asynchronous reset mid-iteration.
        req_funct3 = 3'b000;
        req_a = 32'd13;
        req_b = 32'd3;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        chk("ar_busy_pre", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_rdy", {31'b0, req_ready}, 32'd1);
        chk("ar_valid", {31'b0, resp_valid}, 32'd0);
        chk("ar_data", resp_data, 32'd0);
        chk("ar_aluop", {28'b0, alu_op}, 32'd2);
        chk("ar_srca", alu_src_a, 32'd0);
        chk("ar_srcb", alu_src_b, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_op("mul_after_rst", 3'b000, 32'd13, 32'd3, 32'd39, 33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
